mem_byte_sequencer: RTL and testbench

Initiator side of the byte-wide memory port. Sits in the MEM stage and splits each CPU load/store (byte, halfword, word) into a sequence of single-byte RAM accesses. It drives the request-type/address/write-byte lines into the memory arbiter and reassembles returned read bytes into a 32-bit result. It holds the pipeline via `busy_o` until the access completes; the arbiter gives MEM priority, so every issued byte proceeds without wait.

---
 rtl/memseq_pkg.sv | 40 ++++
 rtl/mem_load_extend.sv | 34 +++
 rtl/mem_byte_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mem_byte_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/memseq_pkg.sv
// Shared types and codes for the byte-wide memory port sequencer and its arbiter.
package memseq_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RTAIL,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] MEMT_NONE  = 2'b00;
    localparam logic [1:0] MEMT_LOAD  = 2'b01;
    localparam logic [1:0] MEMT_STORE = 2'b10;

    // One byte-lane request toward the arbiter.
    typedef struct packed {
        logic [1:0]        mtype;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] wdata;
    } mem_req_t;

    // Index of the final byte for a size code; code 11 behaves as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load result extension for byte/half/word loads.
// MEMSEQ_SIGNEXT_EN enables sign extension; otherwise all loads zero-extend.
module mem_load_extend
    import memseq_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] rdata_c
);

`ifdef MEMSEQ_SIGNEXT_EN
    always_comb begin
        case (size)
            SZ_BYTE: rdata_c = {{24{sign & raw[7]}}, raw[7:0]};
            SZ_HALF: rdata_c = {{16{sign & raw[15]}}, raw[15:0]};
            default: rdata_c = raw;
        endcase
    end
`else
    // Sign handling lives downstream in this build.
    logic unused_sign;
    assign unused_sign = sign;

    always_comb begin
        case (size)
            SZ_BYTE: rdata_c = {24'h000000, raw[7:0]};
            SZ_HALF: rdata_c = {16'h0000, raw[15:0]};
            default: rdata_c = raw;
        endcase
    end
`endif

endmodule

// File: rtl/mem_byte_sequencer.sv
// Splits MEM-stage byte/half/word accesses into single-byte RAM accesses and
// reassembles load data. Build option: MEMSEQ_SIGNEXT_EN (see mem_load_extend).
module mem_byte_sequencer
    import memseq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              busy_o,
    output logic [1:0]        mem_type_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [BYTE_W-1:0] mem_wdata_o,
    input  logic [BYTE_W-1:0] mem_rdata_i
);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              sign_q, sign_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] result_q, result_d;

    mem_req_t          mem_q, mem_d;
    logic              done_d;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] ext_c;

    mem_load_extend u_ext (
        .size    (size_d),
        .sign    (sign_d),
        .raw     (result_d),
        .rdata_c (ext_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            sign_q   <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            mem_q    <= '0;
            done_o   <= 1'b0;
            rdata_o  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            size_q   <= size_d;
            we_q     <= we_d;
            sign_q   <= sign_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            mem_q    <= mem_d;
            done_o   <= done_d;
            rdata_o  <= rdata_d;
        end
    end

    // Next-state, byte index and result assembly.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        size_d   = size_q;
        we_d     = we_q;
        sign_d   = sign_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    size_d   = size_i;
                    we_d     = we_i;
                    sign_d   = sign_i;
                    base_d   = addr_i;
                    wdata_d  = wdata_i;
                    idx_d    = 2'd0;
                    result_d = '0;
                    state_d  = we_i ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                // Read data trails its address by one cycle.
                if (idx_q != 2'd0) begin
                    result_d[{idx_q - 2'd1, 3'b000} +: BYTE_W] = mem_rdata_i;
                end
                if (idx_q == last_idx(size_q)) begin
                    state_d = ST_RTAIL;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_RTAIL: begin
                result_d[{last_idx(size_q), 3'b000} +: BYTE_W] = mem_rdata_i;
                state_d = ST_DONE;
            end
            ST_WRITE: begin
                if (idx_q == last_idx(size_q)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave flops.
    always_comb begin
        mem_d   = '0;
        done_d  = (state_d == ST_DONE);
        rdata_d = '0;

        case (state_d)
            ST_READ: begin
                mem_d.mtype = MEMT_LOAD;
                mem_d.addr  = base_d + ADDR_W'(idx_d);
            end
            ST_WRITE: begin
                mem_d.mtype = MEMT_STORE;
                mem_d.addr  = base_d + ADDR_W'(idx_d);
                mem_d.wdata = wdata_d[{idx_d, 3'b000} +: BYTE_W];
            end
            default: begin
            end
        endcase

        if ((state_d == ST_DONE) && !we_d) begin
            rdata_d = ext_c;
        end
    end

    // Stall as soon as a request appears, release in the DONE cycle.
    assign busy_o = ((state_q == ST_IDLE) && req_i) ||
                    (state_q == ST_READ) || (state_q == ST_RTAIL) ||
                    (state_q == ST_WRITE);

    assign mem_type_o  = mem_q.mtype;
    assign mem_addr_o  = mem_q.addr;
    assign mem_wdata_o = mem_q.wdata;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a byte-bus and result scoreboard.
module tb_mem_byte_sequencer;

    typedef struct packed {
        logic [1:0]  t;
        logic [31:0] a;
        logic [7:0]  d;
    } bus_ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        sign_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        busy_o;
    logic [1:0]  mem_type_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;

    int vectors = 0;
    int miscompares = 0;

    bus_ev_t     bus_q[$];
    logic [31:0] res_q[$];

    mem_byte_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .sign_i      (sign_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .mem_type_o  (mem_type_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h11;
            32'h0000_1001: return 8'h22;
            32'h0000_1002: return 8'h33;
            32'h0000_1003: return 8'h44;
            32'h0000_0020: return 8'h80;
            default:       return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // RAM returns the addressed byte one cycle after the load address.
    always @(posedge clk) begin
        mem_rdata_i <= (mem_type_o == 2'b01) ? ram_byte(mem_addr_o) : 8'hEE;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then score bus activity and completions.
    task automatic tick();
        bus_ev_t ev;
        logic [31:0] r;
        @(posedge clk);
        #1;
        if (mem_type_o != 2'b00) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", {30'd0, mem_type_o}, 32'd0);
            end else begin
                ev = bus_q.pop_front();
                chk("bus_type", {30'd0, mem_type_o}, {30'd0, ev.t});
                chk("bus_addr", mem_addr_o, ev.a);
                if (ev.t == 2'b10) chk("bus_wdata", {24'd0, mem_wdata_o}, {24'd0, ev.d});
            end
        end
        if (done_o) begin
            if (res_q.size() == 0) begin
                chk("done_unexpected", {31'd0, done_o}, 32'd0);
            end else begin
                r = res_q.pop_front();
                chk("rdata", rdata_o, r);
            end
        end
    endtask

    task automatic do_access(input string tag, input logic w, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_r, input int exp_lat,
                             input logic drop, input logic hold);
        int n;
        int lat;
        bus_ev_t ev;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            ev.t = w ? 2'b10 : 2'b01;
            ev.a = a + 32'(i);
            ev.d = w ? 8'(d >> (8 * i)) : 8'h00;
            bus_q.push_back(ev);
        end
        res_q.push_back(exp_r);
        we_i = w; size_i = sz; sign_i = sg; addr_i = a; wdata_i = d; req_i = 1'b1;
        #1;
        chk({tag, "/busy_req"}, {31'd0, busy_o}, 32'd1);
        tick();
        if (drop) begin
            req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; size_i = 2'b00; we_i = ~w;
        end
        lat = 1;
        while (!done_o && lat < 20) begin
            chk({tag, "/busy_active"}, {31'd0, busy_o}, 32'd1);
            tick();
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/busy_done"}, {31'd0, busy_o}, 32'd0);
        req_i = hold;
        tick();
    endtask

    initial begin
        logic [31:0] sext_80;
        bus_ev_t ev;
`ifdef MEMSEQ_SIGNEXT_EN
        sext_80 = 32'hFFFF_FF80;
`else
        sext_80 = 32'h0000_0080;
`endif
        rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sign_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        tick(); tick();
        chk("rst/done", {31'd0, done_o}, 32'd0);
        chk("rst/busy", {31'd0, busy_o}, 32'd0);
        chk("rst/type", {30'd0, mem_type_o}, 32'd0);
        chk("rst/addr", mem_addr_o, 32'd0);
        chk("rst/wdata", {24'd0, mem_wdata_o}, 32'd0);
        chk("rst/rdata", rdata_o, 32'd0);
        rst_n = 1'b1;
        tick();

        do_access("ld_word",   1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'h4433_2211, 6, 1'b0, 1'b0);
        do_access("ld_byte_s", 1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0, sext_80,       3, 1'b0, 1'b0);
        do_access("ld_byte_u", 1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0080, 3, 1'b0, 1'b0);
        do_access("ld_half",   1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0, 32'h0000_4433, 4, 1'b0, 1'b0);
        do_access("ld_sz11",   1'b0, 2'b11, 1'b0, 32'h0000_1000, 32'h0, 32'h4433_2211, 6, 1'b0, 1'b0);
        do_access("st_half",   1'b1, 2'b01, 1'b0, 32'h0000_0007, 32'h0000_ABCD, 32'h0, 3, 1'b0, 1'b0);
        do_access("ld_wrap",   1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h5B5A_A5A4, 6, 1'b0, 1'b0);

        // Reset lands during the third WRITE of a word store.
        for (int i = 0; i < 3; i++) begin
            ev.t = 2'b10; ev.a = 32'h300 + 32'(i); ev.d = 8'(32'hDEAD_BEEF >> (8 * i));
            bus_q.push_back(ev);
        end
        we_i = 1'b1; size_i = 2'b10; sign_i = 1'b0; addr_i = 32'h300; wdata_i = 32'hDEAD_BEEF;
        req_i = 1'b1;
        tick(); tick(); tick();
        chk("rstmid/third_write", mem_addr_o, 32'h302);
        rst_n = 1'b0; req_i = 1'b0;
        tick();
        chk("rstmid/done", {31'd0, done_o}, 32'd0);
        chk("rstmid/busy", {31'd0, busy_o}, 32'd0);
        chk("rstmid/type", {30'd0, mem_type_o}, 32'd0);
        chk("rstmid/addr", mem_addr_o, 32'd0);
        chk("rstmid/wdata", {24'd0, mem_wdata_o}, 32'd0);
        chk("rstmid/rdata", rdata_o, 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("rstmid/no_done", {31'd0, done_o}, 32'd0);
        do_access("ld_after_rst", 1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0, 32'h0000_0022, 3, 1'b0, 1'b0);

        // Request dropped after acceptance, then held through DONE.
        do_access("st_drop", 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h1234_5678, 32'h0, 5, 1'b1, 1'b1);
        chk("hold/busy_idle", {31'd0, busy_o}, 32'd1);
        do_access("st_again", 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h1234_5678, 32'h0, 5, 1'b0, 1'b0);

        tick(); tick();
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
